// File: rtl/spi_master_gen_pkg.sv
// Shared FSM state and SPI mode encodings for spi_master_gen.
package spi_master_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } spi_state_e;

    // {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_master_gen_sck_gen.sv
// SCK timing for spi_master_gen: half-period divider and per-edge strobes.
// Edge k fires when the counter reaches zero; even k is leading, odd k trailing.
module spi_sck_gen #(
    parameter int DW    = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             lead_stb,
    output logic             trail_stb,
    output logic             last_edge
);
    localparam int            EW     = $clog2(2 * DW);
    localparam logic [EW-1:0] K_LAST = EW'(2 * DW - 1);

    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] cnt;
    logic [EW-1:0]    k;
    logic             edge_stb;

    assign edge_stb  = run && (cnt == '0);
    assign lead_stb  = edge_stb && !k[0];
    assign trail_stb = edge_stb && k[0];
    assign last_edge = edge_stb && (k == K_LAST);

    // Counter only ever reloads from div_r, so div at its maximum never overflows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r <= '0;
            cnt   <= '0;
            k     <= '0;
        end else if (load) begin
            div_r <= div;
            cnt   <= div;
            k     <= '0;
        end else if (edge_stb) begin
            cnt <= div_r;
            k   <= k + EW'(1);
        end else if (run) begin
            cnt <= cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_gen.sv
// Parametrised SPI master: DW-bit words, CPOL/CPHA modes, bit order, SCK divider.
// Optional `define SPI_TXBUF_EN adds a one-word TX holding register for back-to-back words.
module spi_master_gen
    import spi_master_gen_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             lsb_first,
    input  logic [DIV_W-1:0] div,
    output logic             sck,
    output logic             sdo,
    input  logic             sdi,
    input  logic             dma_req,
    input  logic [DW-1:0]    dma_din,
    input  logic             cpu_req,
    input  logic [DW-1:0]    cpu_din,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic [DW-1:0]    dout
);
    spi_state_e    state, state_nxt;
    logic          cpol_r, cpha_r, lsb_r;
    logic [1:0]    mode_r;
    logic [DW-1:0] tx_sr, rx_sr, rx_nxt;
    logic [DW-1:0] req_din, ld_din;
    logic          req, begin_xfer;
    logic          lead_stb, trail_stb, last_edge;
    logic          shift_stb, sample_stb;

    function automatic logic first_bit(input logic [DW-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DW-1];
    endfunction

    function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] w, input logic lsb);
        return lsb ? {1'b0, w[DW-1:1]} : {w[DW-2:0], 1'b0};
    endfunction

    assign req     = cpu_req | dma_req;
    assign req_din = dma_req ? dma_din : cpu_din;
    assign busy    = (state == ST_XFER);

`ifdef SPI_TXBUF_EN
    logic          hold_full;
    logic [DW-1:0] hold_din;

    assign start      = req & ~hold_full;
    // A held word chains straight off the last edge so SCK keeps running.
    assign begin_xfer = (!busy && (start || hold_full)) || (last_edge && hold_full);
    assign ld_din     = hold_full ? hold_din : req_din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_din  <= '0;
        end else if (begin_xfer && hold_full) begin
            hold_full <= 1'b0;
        end else if (start && busy) begin
            hold_full <= 1'b1;
            hold_din  <= req_din;
        end
    end
`else
    assign start      = req & ~busy;
    assign begin_xfer = start;
    assign ld_din     = req_din;
`endif

    spi_sck_gen #(.DW(DW), .DIV_W(DIV_W)) u_sck_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (begin_xfer),
        .run       (busy),
        .div       (div),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb),
        .last_edge (last_edge)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (begin_xfer) state_nxt = ST_XFER;
            ST_XFER: if (last_edge && !begin_xfer) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign mode_r     = {cpol_r, cpha_r};
    // The final trailing edge of CPHA=0 has no next bit to present.
    assign shift_stb  = ((mode_r == SPI_MODE1) || (mode_r == SPI_MODE3)) ? lead_stb
                                                                          : (trail_stb && !last_edge);
    assign sample_stb = ((mode_r == SPI_MODE0) || (mode_r == SPI_MODE2)) ? lead_stb : trail_stb;
    assign rx_nxt     = lsb_r ? {sdi, rx_sr[DW-1:1]} : {rx_sr[DW-2:0], sdi};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpol_r <= 1'b0;
            cpha_r <= 1'b0;
            lsb_r  <= 1'b0;
            sck    <= 1'b0;
            sdo    <= 1'b1;
            tx_sr  <= '0;
            rx_sr  <= '0;
            dout   <= '0;
            done   <= 1'b0;
        end else begin
            done <= last_edge;
            if (last_edge) dout <= sample_stb ? rx_nxt : rx_sr;
            if (sample_stb) rx_sr <= rx_nxt;

            if (begin_xfer || !busy) begin
                cpol_r <= cpol;
                sck    <= cpol;
            end else if (lead_stb || trail_stb) begin
                sck <= ~sck;
            end

            if (begin_xfer) begin
                cpha_r <= cpha;
                lsb_r  <= lsb_first;
                if (cpha) begin
                    tx_sr <= ld_din;
                end else begin
                    sdo   <= first_bit(ld_din, lsb_first);
                    tx_sr <= shift_out(ld_din, lsb_first);
                end
            end else if (shift_stb) begin
                sdo   <= first_bit(tx_sr, lsb_r);
                tx_sr <= shift_out(tx_sr, lsb_r);
            end
        end
    end

endmodule

// File: tb/tb_spi_master_gen.sv
// Bench for spi_master_gen: spec vectors, random transfers against a timing/bit-order model,
// plus request-drop, async-reset, idle-CPOL and DW=16 sequences.
module tb_spi_master_gen;

    typedef struct {
        logic        cpu_req;
        logic        dma_req;
        logic        pol;
        logic        pha;
        logic        lsb;
        logic [7:0]  div;
        logic [7:0]  cpu_din;
        logic [7:0]  dma_din;
        logic        loop;
        logic [7:0]  rxw;
        logic [7:0]  exp_dout;
        int          exp_done;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
    logic [7:0]  div = '0;
    logic        sck, sdo, sdi;
    logic        dma_req = 1'b0, cpu_req = 1'b0;
    logic [7:0]  dma_din = '0, cpu_din = '0;
    logic        start, busy, done;
    logic [7:0]  dout;
    logic        loop_en = 1'b0, sdi_drv = 1'b0;

    logic        w_cpol = 1'b0, w_cpha = 1'b0, w_lsb = 1'b0;
    logic [7:0]  w_div = '0;
    logic        w_sck, w_sdo;
    logic        w_req = 1'b0;
    logic [15:0] w_din = '0, w_zero = '0;
    logic        w_start, w_busy, w_done;
    logic [15:0] w_dout;

    int n_cmp = 0;
    int n_bad = 0;

    assign sdi = loop_en ? sdo : sdi_drv;

    always #5 clk = ~clk;

    spi_master_gen #(.DW(8), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .div(div),
        .sck(sck), .sdo(sdo), .sdi(sdi),
        .dma_req(dma_req), .dma_din(dma_din), .cpu_req(cpu_req), .cpu_din(cpu_din),
        .start(start), .busy(busy), .done(done), .dout(dout)
    );

    spi_master_gen #(.DW(16), .DIV_W(8)) dut16 (
        .clk(clk), .rst(rst), .cpol(w_cpol), .cpha(w_cpha), .lsb_first(w_lsb), .div(w_div),
        .sck(w_sck), .sdo(w_sdo), .sdi(w_sdo),
        .dma_req(1'b0), .dma_din(w_zero), .cpu_req(w_req), .cpu_din(w_din),
        .start(w_start), .busy(w_busy), .done(w_done), .dout(w_dout)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Bit i in wire order of word w.
    function automatic logic wbit(input logic [7:0] w, input int i, input logic lsb);
        return lsb ? w[i] : w[7-i];
    endfunction

    task automatic run_xfer(input vec_t v, input string nm);
        logic [7:0] tx;
        logic       sck_prev;
        int d, t, dc, toggles, sdo_err, bd_err, k, i;
        tx = v.dma_req ? v.dma_din : v.cpu_din;
        d  = int'(v.div);
        t  = 2 * 8 * (d + 1) + 1;
        dc = 0; toggles = 0; sdo_err = 0; bd_err = 0;
        @(negedge clk);
        cpol = v.pol; cpha = v.pha; lsb_first = v.lsb; div = v.div;
        cpu_din = v.cpu_din; dma_din = v.dma_din; loop_en = v.loop; sdi_drv = 1'b0;
        cpu_req = v.cpu_req; dma_req = v.dma_req;
        #1 chk({nm, "_start"}, start, 1);
        @(posedge clk);
        #1 cpu_req = 1'b0; dma_req = 1'b0;
        sck_prev = v.pol;
        for (int c = 1; c <= t + 2; c++) begin
            @(negedge clk);
            if (sck !== sck_prev) toggles++;
            sck_prev = sck;
            if (busy !== ((c < t) ? 1'b1 : 1'b0)) bd_err++;
            if (done !== ((c == t) ? 1'b1 : 1'b0)) bd_err++;
            if (done === 1'b1 && dc == 0) dc = c;
            // Before each sampling edge the wire must carry the expected tx bit.
            if (c % (d + 1) == 0) begin
                k = c / (d + 1) - 1;
                if (k < 16 && (k % 2) == int'(v.pha)) begin
                    if (sdo !== wbit(tx, k / 2, v.lsb)) sdo_err++;
                end
            end
            k = (c - 1) / (d + 1);
            i = v.pha ? (k - 1) / 2 : k / 2;
            if (i < 0) i = 0;
            if (i > 7) i = 7;
            sdi_drv = wbit(v.rxw, i, v.lsb);
        end
        chk({nm, "_done_cycle"}, dc, v.exp_done);
        chk({nm, "_dout"}, dout, v.exp_dout);
        chk({nm, "_sck_edges"}, toggles, 16);
        chk({nm, "_sdo_bits"}, sdo_err, 0);
        chk({nm, "_busy_done"}, bd_err, 0);
        chk({nm, "_sck_idle"}, sck, v.pol);
        chk({nm, "_sdo_hold"}, sdo, wbit(tx, 7, v.lsb));
    endtask

    vec_t tbl[7];
    vec_t rv;

    initial begin
        int dc;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   8'hA5, 8'h00, 1'b1, 8'h00, 8'hA5, 17};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2,   8'h00, 8'h3C, 1'b0, 8'hFF, 8'hFF, 49};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0,   8'h01, 8'h00, 1'b1, 8'h00, 8'h01, 17};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'h11, 8'h22, 1'b1, 8'h00, 8'h22, 17};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1,   8'h96, 8'h00, 1'b0, 8'h5B, 8'h5B, 33};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3,   8'h0F, 8'h00, 1'b0, 8'hC1, 8'hC1, 65};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd255, 8'h81, 8'h00, 1'b1, 8'h00, 8'h81, 4097};

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_sck", sck, 0);
        chk("reset_sdo", sdo, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_dout", dout, 0);
        rst = 1'b0;

        // Idle SCK follows cpol one clock later.
        @(negedge clk); cpol = 1'b1;
        @(negedge clk); chk("idle_cpol_hi", sck, 1);
        cpol = 1'b0;
        @(negedge clk); chk("idle_cpol_lo", sck, 0);

        for (int n = 0; n < 7; n++) run_xfer(tbl[n], $sformatf("tbl%0d", n));

        for (int r = 0; r < 20; r++) begin
            rv.cpu_req  = 1'($urandom_range(0, 1));
            rv.dma_req  = rv.cpu_req ? 1'($urandom_range(0, 1)) : 1'b1;
            rv.pol      = 1'($urandom_range(0, 1));
            rv.pha      = 1'($urandom_range(0, 1));
            rv.lsb      = 1'($urandom_range(0, 1));
            rv.div      = 8'($urandom_range(0, 4));
            rv.cpu_din  = 8'($urandom);
            rv.dma_din  = 8'($urandom);
            rv.loop     = 1'($urandom_range(0, 1));
            rv.rxw      = 8'($urandom);
            rv.exp_dout = rv.loop ? (rv.dma_req ? rv.dma_din : rv.cpu_din) : rv.rxw;
            rv.exp_done = 2 * 8 * (int'(rv.div) + 1) + 1;
            run_xfer(rv, $sformatf("rnd%0d", r));
        end

        // A request while busy is dropped; the first word completes untouched.
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; div = 8'd0; loop_en = 1'b1;
        cpu_din = 8'hA5; cpu_req = 1'b1;
        @(posedge clk); #1 cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        cpu_din = 8'h5A; cpu_req = 1'b1;
        #1 chk("drop_start", start, 0);
        chk("drop_busy", busy, 1);
        @(posedge clk); #1 cpu_req = 1'b0;
        dc = 0;
        for (int c = 3; c <= 40 && dc == 0; c++) begin
            @(negedge clk);
            if (done === 1'b1) dc = c;
        end
        chk("drop_done_cycle", dc, 17);
        chk("drop_dout", dout, 8'hA5);
        repeat (2) @(negedge clk);
        chk("drop_no_second", busy, 0);

        // Async reset after edge 5 of a mode-2 transfer.
        @(negedge clk);
        cpol = 1'b1; cpha = 1'b0; div = 8'd0; loop_en = 1'b1; cpu_din = 8'hC3; cpu_req = 1'b1;
        @(posedge clk); #1 cpu_req = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_sck", sck, 0);
        chk("rst_mid_sdo", sdo, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_dout", dout, 0);
        @(negedge clk); rst = 1'b0;
        run_xfer(tbl[0], "after_rst");

        // DW=16, mode 1, div=1, loopback.
        @(negedge clk);
        w_cpol = 1'b0; w_cpha = 1'b1; w_lsb = 1'b0; w_div = 8'd1; w_din = 16'hBEEF; w_req = 1'b1;
        #1 chk("w16_start", w_start, 1);
        @(posedge clk); #1 w_req = 1'b0;
        dc = 0;
        for (int c = 1; c <= 80 && dc == 0; c++) begin
            @(negedge clk);
            if (w_done === 1'b1) dc = c;
        end
        chk("w16_done_cycle", dc, 2 * 16 * 2 + 1);
        chk("w16_dout", w_dout, 16'hBEEF);
        chk("w16_busy_low", w_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
